// File: rtl/btn_input_module.sv
// Push-button front end: sync, debounce, press/release/long-press events.
// Ports: clk, rst (sync, active-high), btn_in -> btn_level, evt_* handshake.
module btn_input_module #(
  parameter int N_BTN = 4,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int LONG_CYCLES = 25_000_000,
  parameter int CNT_W = 25,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_idx,
  output logic [1:0]       evt_type,
  output logic             evt_overflow,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX =
    CNT_W'(LONG_CYCLES);
  localparam int NP = 3 * N_BTN;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] s;
  logic [N_BTN-1:0] lvl_d;
  logic [CNT_W-1:0] db_cnt [N_BTN];
  logic [CNT_W-1:0] hold_cnt [N_BTN];
  logic [N_BTN-1:0] long_done;

  logic [N_BTN-1:0] press_p;
  logic [N_BTN-1:0] rel_p;
  logic [N_BTN-1:0] long_p;

  // Pending bit 3*c+t: t=0 press, t=1 long, t=2 release.
  logic [NP-1:0] pend;
  logic [NP-1:0] pulse;
  logic [NP-1:0] hit;
  logic [NP-1:0] take;
  logic [NP-1:0] drop;
  logic          found;
  logic          load;
  logic [1:0]    sel_idx;
  logic [1:0]    sel_type;

  function automatic logic [1:0] ev_code(input int t);
    case (t)
      0:       return 2'b01;
      1:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  assign s = sync2 ^ {N_BTN{BTN_ACTIVE_LOW}};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      btn_level <= '0;
      lvl_d     <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      lvl_d <= btn_level;
      for (int i = 0; i < N_BTN; i++) begin
        if (s[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]    <= '0;
          btn_level[i] <= ~btn_level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press_p = btn_level & ~lvl_d;
  assign rel_p   = ~btn_level & lvl_d;

  // Gated by the level so a long event can never trail its release.
  always_comb begin
    long_p = '0;
    for (int i = 0; i < N_BTN; i++) begin
      long_p[i] = btn_level[i] && !long_done[i]
                  && (hold_cnt[i] == LONG_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_done <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!btn_level[i]) begin
          hold_cnt[i]  <= '0;
          long_done[i] <= 1'b0;
        end else begin
          if (hold_cnt[i] != LONG_MAX) begin
            hold_cnt[i] <= hold_cnt[i] + 1'b1;
          end
          if (long_p[i]) begin
            long_done[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    pulse = '0;
    for (int c = 0; c < N_BTN; c++) begin
      pulse[3*c]   = press_p[c];
      pulse[3*c+1] = long_p[c];
      pulse[3*c+2] = rel_p[c];
    end
  end

  // Lowest flat index wins: lowest channel, then press/long/release.
  always_comb begin
    hit      = '0;
    found    = 1'b0;
    sel_idx  = '0;
    sel_type = '0;
    for (int c = 0; c < N_BTN; c++) begin
      for (int t = 0; t < 3; t++) begin
        if (!found && pend[3*c+t]) begin
          found         = 1'b1;
          hit[3*c+t]    = 1'b1;
          sel_idx       = 2'(c);
          sel_type      = ev_code(t);
        end
      end
    end
  end

  assign load = !evt_valid || evt_ready;
  assign take = load ? hit : '0;
  assign drop = pulse & pend & ~take;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~take) | pulse;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_type  <= '0;
    end else if (load) begin
      if (found) begin
        evt_valid <= 1'b1;
        evt_idx   <= sel_idx;
        evt_type  <= sel_type;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_overflow <= 1'b0;
    end else if (|drop) begin
      evt_overflow <= 1'b1;
    end else if (ovf_clr) begin
      evt_overflow <= 1'b0;
    end
  end

endmodule
